// File: rtl/instr_fetch_queue.sv
// Fetch stage between the program counter and decode: issues instruction-memory reads under a
// credit check and buffers returned words with their PC tags. Define FETCH_STATS_EN for the stall counter.
module instr_fetch_queue #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      pc_in,
  input  logic                   flush,
  output logic                   pc_hold,
  output logic                   imem_rd,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_W-1:0]     out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            stall_cycles
);
  // Handshake: the head transfers on a cycle where out_valid && out_ready are both high at
  // the clock edge; out_valid never depends on out_ready.

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_U = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_tag;
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];

  logic [PTR_W+1:0]   w_used;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  // An in-flight read already owns a slot, so it counts against credit.
  assign w_used  = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
  assign w_issue = !reset && !flush && (w_used < DEPTH_U);
  assign w_push  = r_inflight && !flush;
  assign w_pop   = out_valid && out_ready;

  assign imem_rd   = w_issue;
  assign imem_addr = pc_in;
  assign pc_hold   = !reset && !flush && !w_issue;

  assign occupancy = r_count;
  assign out_valid = (r_count != '0);
  assign out_instr = out_valid ? r_instr_mem[r_rptr] : '0;
  assign out_pc    = out_valid ? r_pc_mem[r_rptr]    : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else if (flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_tag <= pc_in;
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wptr] <= imem_rdata;
      r_pc_mem[r_wptr]    <= r_tag;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == DEPTH_C)));

`ifdef FETCH_STATS_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (flush) begin
      r_stall <= '0;
    end else if (pc_hold && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed bench for instr_fetch_queue against a queue-based reference model;
// the memory returns 16'hA000 | addr one cycle after each read.
module tb_instr_fetch_queue;
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  pc_in;
  logic               flush;
  logic               pc_hold;
  logic               imem_rd;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [$clog2(DEPTH):0] occupancy;
  logic [15:0]        stall_cycles;

  instr_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .pc_hold(pc_hold),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: PC tags buffered in order, plus the one outstanding read
  logic [ADDR_W-1:0] exp_q[$];
  int                pend;
  logic [ADDR_W-1:0] pend_pc;
  int                exp_stall;
  logic [ADDR_W-1:0] pc;
  logic              req_v;
  logic [ADDR_W-1:0] req_addr;
  int                n_cmp = 0;
  int                n_err = 0;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 16'hA000 | {12'h000, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: each is entered and left 1 time unit after a rising edge
  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    pc_in = '0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_rd", imem_rd, 0);
    chk("rst_hold", pc_hold, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_stall", stall_cycles, 0);
    exp_q.delete();
    pend = 0;
    exp_stall = 0;
    pc = '0;
    req_v = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    imem_rdata = 16'($urandom);
  endtask

  task automatic cycle(input logic fl, input logic [ADDR_W-1:0] tgt, input logic rdy);
    logic              e_issue;
    logic              e_hold;
    logic              e_valid;
    logic [ADDR_W-1:0] e_pc;
    logic [INSTR_W-1:0] e_instr;
    flush = fl;
    out_ready = rdy;
    pc_in = pc;
    @(negedge clk);
    e_issue = !fl && ((exp_q.size() + pend) < DEPTH);
    e_hold  = !e_issue && !fl;
    e_valid = (exp_q.size() != 0);
    e_pc    = e_valid ? exp_q[0] : '0;
    e_instr = e_valid ? mem_word(exp_q[0]) : '0;
    chk("imem_rd", imem_rd, e_issue);
    chk("imem_addr", imem_addr, pc);
    chk("pc_hold", pc_hold, e_hold);
    chk("out_valid", out_valid, e_valid);
    chk("out_pc", out_pc, e_pc);
    chk("out_instr", out_instr, e_instr);
    chk("occupancy", occupancy, exp_q.size());
    chk("stall_cycles", stall_cycles, exp_stall);
    req_v = imem_rd;
    req_addr = imem_addr;
    if (fl) begin
      exp_q.delete();
      pend = 0;
      exp_stall = 0;
      pc = tgt;
    end else begin
      if (e_valid && rdy) void'(exp_q.pop_front());
      if (pend != 0) exp_q.push_back(pend_pc);
      pend = e_issue ? 1 : 0;
      pend_pc = pc;
`ifdef FETCH_STATS_EN
      if (e_hold && exp_stall < 65535) exp_stall++;
`endif
      if (!e_hold) pc = pc + 1'b1;
    end
    @(posedge clk);
    #1;
    imem_rdata = req_v ? mem_word(req_addr) : 16'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    pc_in = '0;
    imem_rdata = '0;
    pend = 0;
    pend_pc = '0;
    exp_stall = 0;
    pc = '0;
    req_v = 1'b0;
    req_addr = '0;
    @(posedge clk);
    #1;

    // steady streaming
    do_reset();
    repeat (12) cycle(1'b0, '0, 1'b1);

    // back-pressure, stall counting, flush clearing the counter, then drain
    do_reset();
    repeat (20) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 4'd0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1);

    // redirect with a full buffer and a read in flight
    do_reset();
    repeat (4) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 4'd9, 1'b0);
    repeat (6) cycle(1'b0, '0, 1'b1);

    // pointer wrap with alternating ready
    do_reset();
    for (int i = 0; i < 24; i++) cycle(1'b0, '0, i[0]);

    // reset while entries are buffered and a read is outstanding
    do_reset();
    repeat (3) cycle(1'b0, '0, 1'b0);
    do_reset();
    repeat (6) cycle(1'b0, '0, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) do_reset();
      cycle($urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
